// File: rtl/pairing_io_ctrl.sv
// Host-side bridge to the pairing core's bit-serial register port: sequences WRITE/READ
// transfers over sel/addr/update/ready/i/w and runs the core between hold release and done.
module pairing_io_ctrl #(
    parameter int unsigned WIDTH = 198,
    parameter int unsigned AW    = 6,
    parameter int unsigned CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic             pr_hold,
    output logic             pr_sel,
    output logic [AW-1:0]    pr_addr,
    output logic             pr_update,
    output logic             pr_ready,
    output logic             pr_i,
    output logic             pr_w,
    input  logic             pr_o,
    input  logic             pr_done
);

    typedef enum logic [2:0] {
        IDLE, W_UPD, W_SHIFT, W_COMMIT, R_ADDR, R_UPD, R_SHIFT, RUN
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_START = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            pr_hold   <= 1'b1;
            pr_sel    <= 1'b0;
            pr_addr   <= '0;
            pr_update <= 1'b0;
            pr_ready  <= 1'b0;
            pr_i      <= 1'b0;
            pr_w      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            // done is sampled every cycle so a level already high at START is not an edge
            done_q    <= pr_done;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        case (op_t'(cmd_op))
                            OP_WRITE: begin
                                state     <= W_UPD;
                                cmd_ready <= 1'b0;
                                pr_sel    <= 1'b1;
                                pr_addr   <= cmd_addr;
                                pr_update <= 1'b1;
                                shreg     <= cmd_data;
                            end
                            OP_READ: begin
                                state     <= R_ADDR;
                                cmd_ready <= 1'b0;
                                pr_sel    <= 1'b1;
                                pr_addr   <= cmd_addr;
                            end
                            OP_START: begin
                                state     <= RUN;
                                cmd_ready <= 1'b0;
                                pr_hold   <= 1'b0;
                                pr_sel    <= 1'b0;
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                W_UPD: begin
                    pr_update <= 1'b0;
                    pr_ready  <= 1'b1;
                    pr_i      <= shreg[0];
                    shreg     <= {1'b0, shreg[WIDTH-1:1]};
                    cnt       <= '0;
                    state     <= W_SHIFT;
                end
                W_SHIFT: begin
                    // cnt tracks the bit currently on pr_i
                    if (cnt == LAST) begin
                        pr_ready <= 1'b0;
                        pr_i     <= 1'b0;
                        pr_w     <= 1'b1;
                        state    <= W_COMMIT;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        pr_i  <= shreg[0];
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                    end
                end
                W_COMMIT: begin
                    pr_w      <= 1'b0;
                    rsp_valid <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                R_ADDR: begin
                    pr_update <= 1'b1;
                    state     <= R_UPD;
                end
                R_UPD: begin
                    pr_update <= 1'b0;
                    pr_ready  <= 1'b1;
                    cnt       <= '0;
                    state     <= R_SHIFT;
                end
                R_SHIFT: begin
                    shreg <= {pr_o, shreg[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        pr_ready  <= 1'b0;
                        rsp_data  <= {pr_o, shreg[WIDTH-1:1]};
                        rsp_valid <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (pr_done && !done_q) begin
                        pr_hold   <= 1'b1;
                        rsp_valid <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
